// File: rtl/jpeg_byte_packer.sv
// JPEG bitstream back end: packs 0..32-bit code chunks MSB-first into bytes,
// buffers them in a byte FIFO and emits one byte per cycle with 0xFF/0x00 stuffing.
module jpeg_byte_packer #(
    parameter int FIFO_DEPTH = 256
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [5:0]  ilength,
    input  logic [31:0] idata,
    input  logic        inostuff,
    output logic [2:0]  rest,
    output logic        valid,
    output logic [7:0]  rdata,
    output logic        overflow
);
    localparam int AW = $clog2(FIFO_DEPTH);

    logic [6:0]  acc;
    logic [6:0]  acc_mark;
    logic [2:0]  pcnt;

    logic [5:0]  len;
    logic [31:0] mask;
    logic [39:0] comb_bits;
    logic [39:0] comb_mark;
    logic [5:0]  total;
    logic [2:0]  nbytes;
    logic [2:0]  pcnt_next;
    logic [6:0]  keep;
    logic [7:0]  byte_d [4];
    logic        byte_x [4];

    logic [8:0]  mem [FIFO_DEPTH];
    logic [AW:0] wptr;
    logic [AW:0] rptr;
    logic [AW:0] count;
    logic [AW:0] free;
    logic [2:0]  nwr;
    logic [8:0]  head;
    logic        pop;
    logic        stuff;

    // Pending bits live right-aligned; the new chunk is shifted in below them,
    // so byte k of this cycle sits at bits [total-1-8k -: 8].
    always_comb begin
        len       = (ilength > 6'd32) ? 6'd32 : ilength;
        mask      = (len == 6'd0) ? 32'd0 : (32'hFFFF_FFFF >> (6'd32 - len));
        comb_bits = ({33'd0, acc} << len) | {8'd0, idata & mask};
        comb_mark = ({33'd0, acc_mark} << len) | {8'd0, (inostuff ? mask : 32'd0)};
        total     = {3'd0, pcnt} + len;
        nbytes    = total[5:3];
        pcnt_next = total[2:0];
        keep      = 7'((8'd1 << pcnt_next) - 8'd1);
        for (int k = 0; k < 4; k++) begin
            byte_d[k] = 8'(comb_bits >> (total - 6'(8 * k + 8)));
            byte_x[k] = &(8'(comb_mark >> (total - 6'(8 * k + 8))));
        end
    end

    // Free space is judged before this cycle's pop, so a full FIFO never
    // accepts a byte into the slot that is being read out.
    always_comb begin
        count = wptr - rptr;
        free  = (AW + 1)'(FIFO_DEPTH) - count;
        nwr   = ((AW + 1)'(nbytes) > free) ? free[2:0] : nbytes;
        head  = mem[rptr[AW-1:0]];
        pop   = !stuff && (count != '0);
    end

    always_ff @(posedge clk) begin
        for (int k = 0; k < 4; k++) begin
            if (3'(k) < nwr)
                mem[AW'(wptr[AW-1:0] + AW'(k))] <= {byte_x[k], byte_d[k]};
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            acc      <= '0;
            acc_mark <= '0;
            pcnt     <= '0;
            rest     <= '0;
            wptr     <= '0;
            rptr     <= '0;
            valid    <= 1'b0;
            rdata    <= '0;
            stuff    <= 1'b0;
            overflow <= 1'b0;
        end else begin
            acc      <= comb_bits[6:0] & keep;
            acc_mark <= comb_mark[6:0] & keep;
            pcnt     <= pcnt_next;
            rest     <= 3'd0 - pcnt_next;
            wptr     <= wptr + (AW + 1)'(nwr);
            if (nbytes > nwr)
                overflow <= 1'b1;

            if (stuff) begin
                valid <= 1'b1;
                rdata <= 8'h00;
                stuff <= 1'b0;
            end else if (pop) begin
                valid <= 1'b1;
                rdata <= head[7:0];
                stuff <= (head == 9'h0FF);
                rptr  <= rptr + 1'b1;
            end else begin
                valid <= 1'b0;
            end
        end
    end
endmodule

// File: tb/tb_jpeg_byte_packer.sv
// Bench for jpeg_byte_packer: queue-based bitstream model checked every cycle,
// directed test-plan sequences with literal expectations, then random traffic.
module tb_jpeg_byte_packer;
    localparam int DEPTH = 8;

    logic        clk = 1'b0;
    logic        rst;
    logic [5:0]  ilength;
    logic [31:0] idata;
    logic        inostuff;
    logic [2:0]  rest;
    logic        valid;
    logic [7:0]  rdata;
    logic        overflow;

    jpeg_byte_packer #(.FIFO_DEPTH(DEPTH)) dut (
        .clk(clk), .rst(rst), .ilength(ilength), .idata(idata), .inostuff(inostuff),
        .rest(rest), .valid(valid), .rdata(rdata), .overflow(overflow)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;
    int sent  = 0;
    bit chk_en = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic cmp(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Reference model: a bit queue with per-bit marks and a byte queue.
    bit          mb[$];
    bit          mm[$];
    logic [8:0]  mf[$];
    logic [8:0]  me;
    logic        e_valid, e_ovf;
    logic [7:0]  e_rdata, m_byte;
    logic [2:0]  e_rest;
    bit          m_stuff, m_all;
    int          m_free, m_len, m_wr;

    always @(posedge clk) begin
        if (rst) begin
            mb.delete(); mm.delete(); mf.delete();
            e_valid = 0; e_rdata = 0; e_rest = 0; e_ovf = 0; m_stuff = 0;
        end else begin
            m_free = DEPTH - mf.size();
            if (m_stuff) begin
                e_valid = 1; e_rdata = 8'h00; m_stuff = 0;
            end else if (mf.size() > 0) begin
                me = mf.pop_front();
                e_valid = 1; e_rdata = me[7:0];
                m_stuff = (me[7:0] == 8'hFF) && !me[8];
            end else begin
                e_valid = 0;
            end
            m_len = (ilength > 32) ? 32 : int'(ilength);
            for (int i = m_len - 1; i >= 0; i--) begin
                mb.push_back(idata[i]);
                mm.push_back(inostuff);
            end
            m_wr = 0;
            while (mb.size() >= 8) begin
                m_byte = 0; m_all = 1;
                for (int j = 0; j < 8; j++) begin
                    m_byte = {m_byte[6:0], mb.pop_front()};
                    m_all  = m_all & mm.pop_front();
                end
                if (m_wr < m_free) begin
                    mf.push_back({m_all, m_byte});
                    m_wr++;
                end else begin
                    e_ovf = 1;
                end
            end
            e_rest = 3'((8 - (mb.size() % 8)) % 8);
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            cmp("valid", {31'd0, valid}, {31'd0, e_valid});
            cmp("rdata", {24'd0, rdata}, {24'd0, e_rdata});
            cmp("rest", {29'd0, rest}, {29'd0, e_rest});
            cmp("overflow", {31'd0, overflow}, {31'd0, e_ovf});
        end
    end

    // Output log of the DUT for directed sequence checks.
    logic [7:0] lb[$];
    int         lc[$];
    logic [7:0] expq[$];

    always @(negedge clk) begin
        if (valid === 1'b1) begin
            lb.push_back(rdata);
            lc.push_back(cyc);
        end
    end

    task automatic drive(input int l, input logic [31:0] d, input logic n);
        ilength  = 6'(l);
        idata    = d;
        inostuff = n;
        sent     = cyc;
        @(negedge clk);
        ilength  = 0;
        idata    = $urandom;
        inostuff = 0;
    endtask

    task automatic idle(input int n);
        ilength = 0;
        repeat (n) @(negedge clk);
    endtask

    task automatic clear_log();
        lb.delete();
        lc.delete();
    endtask

    task automatic check_log(input string name, input bit consec);
        cmp($sformatf("%s_count", name), lb.size(), expq.size());
        for (int i = 0; i < expq.size() && i < lb.size(); i++) begin
            cmp($sformatf("%s_byte%0d", name, i), {24'd0, lb[i]}, {24'd0, expq[i]});
            if (consec && i > 0)
                cmp($sformatf("%s_gap%0d", name, i), lc[i] - lc[i-1], 1);
        end
    endtask

    function automatic logic [31:0] rand_data();
        logic [31:0] d;
        d = $urandom;
        for (int b = 0; b < 4; b++)
            if ($urandom_range(0, 3) == 0) d[b*8 +: 8] = 8'hFF;
        return d;
    endfunction

    initial begin
        rst = 1; ilength = 0; idata = 0; inostuff = 0;
        repeat (2) @(negedge clk);
        chk_en = 1;
        cmp("rst_valid", {31'd0, valid}, 0);
        cmp("rst_rdata", {24'd0, rdata}, 0);
        cmp("rst_rest", {29'd0, rest}, 0);
        cmp("rst_ovf", {31'd0, overflow}, 0);
        rst = 0;
        idle(2);

        clear_log();
        drive(8, 32'h0000_00D8, 0);
        cmp("d8_rest", {29'd0, rest}, 0);
        idle(6);
        expq = '{8'hD8};
        check_log("d8", 0);
        if (lc.size() > 0) cmp("d8_latency", lc[0] - sent, 2);

        clear_log();
        drive(3, 32'h5, 0);
        cmp("rest_after3", {29'd0, rest}, 5);
        cmp("model_rest_after3", {29'd0, e_rest}, 5);
        drive(5, 32'h06, 0);
        drive(8, 32'h12, 0);
        idle(6);
        expq = '{8'hA6, 8'h12};
        check_log("a6_12", 0);

        clear_log();
        drive(8, 32'hFFFF_FFFF, 0);
        idle(6);
        expq = '{8'hFF, 8'h00};
        check_log("ff_stuff", 1);

        clear_log();
        drive(8, 32'hFFFF_FFFF, 1);
        idle(6);
        expq = '{8'hFF};
        check_log("ff_marker", 0);

        clear_log();
        drive(32, 32'h11FF_2233, 0);
        idle(8);
        expq = '{8'h11, 8'hFF, 8'h00, 8'h22, 8'h33};
        check_log("word", 1);

        clear_log();
        drive(4, 32'hF, 1);
        drive(4, 32'hF, 0);
        idle(6);
        expq = '{8'hFF, 8'h00};
        check_log("mixed_mark", 1);

        for (int i = 0; i < 9; i++) drive(32, rand_data(), 0);
        idle(2);
        cmp("ovf_set", {31'd0, overflow}, 1);
        cmp("model_ovf_set", {31'd0, e_ovf}, 1);
        idle(3);
        cmp("ovf_sticky", {31'd0, overflow}, 1);
        drive(3, 32'h5, 0);
        rst = 1;
        @(negedge clk);
        cmp("midrst_valid", {31'd0, valid}, 0);
        cmp("midrst_rest", {29'd0, rest}, 0);
        cmp("midrst_ovf", {31'd0, overflow}, 0);
        rst = 0;
        idle(4);
        cmp("after_rst_valid", {31'd0, valid}, 0);

        for (int c = 0; c < 4000; c++) begin
            rst = ($urandom_range(0, 399) == 0);
            if ($urandom_range(0, 99) < 35) begin
                ilength  = ($urandom_range(0, 19) == 0) ? 6'($urandom_range(33, 63))
                                                         : 6'($urandom_range(1, 32));
                idata    = rand_data();
                inostuff = ($urandom_range(0, 3) == 0);
            end else begin
                ilength  = 0;
                idata    = $urandom;
                inostuff = $urandom_range(0, 1);
            end
            @(negedge clk);
        end
        rst = 0;
        idle(20);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
